adsb_squitter_validator: RTL and testbench



---
 rtl/adsb_squitter_validator.sv | 169 ++++++++++++++++
 tb/tb_adsb_squitter_validator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsb_squitter_validator.sv
// ADS-B squitter validator: recomputes the Mode S CRC-24 over the 88-bit
// message field, optionally filters on downlink format (DF17/DF18 only),
// forwards good squitters as single-beat AXI-Stream transfers and keeps
// saturating statistics counters. Upstream ignores tready, so beats that
// arrive while busy are dropped and counted.
module adsb_squitter_validator #(
  parameter int          SQUITTER_LENGTH = 112,
  parameter int          BITS_PER_CYCLE  = 8,
  parameter logic [23:0] CRC_POLY        = 24'hFFF409,
  parameter int          COUNT_WIDTH     = 32
) (
  input  logic                       s00_axis_aclk,
  input  logic                       s00_axis_areset,
  input  logic                       s00_axis_tvalid,
  input  logic [SQUITTER_LENGTH-1:0] s00_axis_tdata,
  input  logic                       s00_axis_tlast,
  output logic                       s00_axis_tready,
  output logic                       m00_axis_tvalid,
  output logic [SQUITTER_LENGTH-1:0] m00_axis_tdata,
  output logic                       m00_axis_tlast,
  input  logic                       m00_axis_tready,
  input  logic                       df_filter_en,
  output logic [COUNT_WIDTH-1:0]     crc_ok_count,
  output logic [COUNT_WIDTH-1:0]     crc_fail_count,
  output logic [COUNT_WIDTH-1:0]     df_reject_count,
  output logic [COUNT_WIDTH-1:0]     dropped_count
);

  localparam int MSG_W      = SQUITTER_LENGTH - 24;
  localparam int NUM_CHUNKS = MSG_W / BITS_PER_CYCLE;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_W      = $clog2(SQUITTER_LENGTH);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CRC, S_CHECK, S_OUTPUT} state_t;

  state_t                     state, state_next;
  logic [SQUITTER_LENGTH-1:0] buffer;
  logic [23:0]                crc;
  logic [CNT_W-1:0]           chunk_cnt;
  logic [IDX_W-1:0]           top_idx;
  logic [BITS_PER_CYCLE-1:0]  chunk_bits;
  logic [4:0]                 df;
  logic                       crc_good, df_ok, drop;
  logic                       accept, crc_step, inc_fail, inc_reject, load_out, deliver;
  logic                       unused_tlast;

  // Shift one chunk of message bits, MSB first, through the Mode S LFSR.
  function automatic logic [23:0] crc_chunk(input logic [23:0] crc_in,
                                            input logic [BITS_PER_CYCLE-1:0] bits);
    logic [23:0] c;
    logic        fb;
    c = crc_in;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      fb = c[23] ^ bits[i];
      c  = {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
    end
    return c;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign unused_tlast    = s00_axis_tlast;
  assign s00_axis_tready = (state == S_IDLE);
  assign m00_axis_tvalid = (state == S_OUTPUT);
  assign m00_axis_tlast  = (state == S_OUTPUT);
  assign drop            = s00_axis_tvalid && !s00_axis_tready;
  assign crc_good        = (crc == buffer[23:0]);
  assign df              = buffer[SQUITTER_LENGTH-1 -: 5];
  assign df_ok           = !df_filter_en || (df == 5'd17) || (df == 5'd18);

  // Select the message chunk addressed by the chunk counter.
  always_comb begin
    top_idx    = IDX_W'(SQUITTER_LENGTH - 1 - BITS_PER_CYCLE * int'(chunk_cnt));
    chunk_bits = buffer[top_idx -: BITS_PER_CYCLE];
  end

  // FSM state register.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) state <= S_IDLE;
    else                 state <= state_next;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    crc_step   = 1'b0;
    inc_fail   = 1'b0;
    inc_reject = 1'b0;
    load_out   = 1'b0;
    deliver    = 1'b0;
    case (state)
      S_IDLE: begin
        if (s00_axis_tvalid) begin
          accept     = 1'b1;
          state_next = S_CRC;
        end
      end
      S_CRC: begin
        crc_step = 1'b1;
        if (chunk_cnt == LAST_CHUNK) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!crc_good) begin
          inc_fail   = 1'b1;
          state_next = S_IDLE;
        end else if (!df_ok) begin
          inc_reject = 1'b1;
          state_next = S_IDLE;
        end else begin
          load_out   = 1'b1;
          state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (m00_axis_tready) begin
          deliver    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the accepted squitter; held until the next acceptance.
  always_ff @(posedge s00_axis_aclk) begin
    if (accept) buffer <= s00_axis_tdata;
  end

  // CRC register and chunk counter.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      crc       <= '0;
      chunk_cnt <= '0;
    end else if (accept) begin
      crc       <= '0;
      chunk_cnt <= '0;
    end else if (crc_step) begin
      crc       <= crc_chunk(crc, chunk_bits);
      chunk_cnt <= (chunk_cnt == LAST_CHUNK) ? '0 : chunk_cnt + CNT_W'(1);
    end
  end

  // Output data register, stable for the whole OUTPUT state.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) m00_axis_tdata <= '0;
    else if (load_out)   m00_axis_tdata <= buffer;
  end

  // Independent saturating statistics counters.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      crc_ok_count    <= '0;
      crc_fail_count  <= '0;
      df_reject_count <= '0;
      dropped_count   <= '0;
    end else begin
      if (deliver)    crc_ok_count    <= sat_inc(crc_ok_count);
      if (inc_fail)   crc_fail_count  <= sat_inc(crc_fail_count);
      if (inc_reject) df_reject_count <= sat_inc(df_reject_count);
      if (drop)       dropped_count   <= sat_inc(dropped_count);
    end
  end

endmodule

// File: tb/tb_adsb_squitter_validator.sv
// Directed testbench for adsb_squitter_validator: main instance with
// BITS_PER_CYCLE=8 plus 1-bit and 88-bit instances (the latter with 2-bit
// counters to reach saturation quickly).
module tb_adsb_squitter_validator;

  localparam logic [111:0] F17 = 112'h8D4840D6202CC371C32CE0576098;

  logic         clk, rst;
  logic         s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready, df_en;
  logic [111:0] s_tdata, m_tdata;
  logic [31:0]  ok_cnt, fail_cnt, rej_cnt, drop_cnt;

  logic         a_tvalid, a_tready, a_mvalid, a_mlast;
  logic [111:0] a_mdata;
  logic [31:0]  a_ok, a_fail, a_rej, a_drop;

  logic         b_tvalid, b_tready, b_mvalid, b_mlast;
  logic [111:0] b_mdata;
  logic [1:0]   b_ok, b_fail, b_rej, b_drop;

  int n_tests = 0;
  int n_fail  = 0;
  int beats = 0, a_beats = 0, b_beats = 0;
  logic [111:0] beat_data, a_data, b_data;
  logic         beat_last;
  logic [111:0] f20, f17_bad;

  adsb_squitter_validator dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tlast(m_tlast),
    .m00_axis_tready(m_tready), .df_filter_en(df_en),
    .crc_ok_count(ok_cnt), .crc_fail_count(fail_cnt),
    .df_reject_count(rej_cnt), .dropped_count(drop_cnt));

  adsb_squitter_validator #(.BITS_PER_CYCLE(1)) dut_b1 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(a_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(a_tready),
    .m00_axis_tvalid(a_mvalid), .m00_axis_tdata(a_mdata), .m00_axis_tlast(a_mlast),
    .m00_axis_tready(1'b1), .df_filter_en(df_en),
    .crc_ok_count(a_ok), .crc_fail_count(a_fail),
    .df_reject_count(a_rej), .dropped_count(a_drop));

  adsb_squitter_validator #(.BITS_PER_CYCLE(88), .COUNT_WIDTH(2)) dut_b88 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(b_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(b_tready),
    .m00_axis_tvalid(b_mvalid), .m00_axis_tdata(b_mdata), .m00_axis_tlast(b_mlast),
    .m00_axis_tready(1'b1), .df_filter_en(df_en),
    .crc_ok_count(b_ok), .crc_fail_count(b_fail),
    .df_reject_count(b_rej), .dropped_count(b_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output beat monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin beats++; beat_data = m_tdata; beat_last = m_tlast; end
    if (a_mvalid && a_mlast) begin a_beats++; a_data = a_mdata; end
    if (b_mvalid && b_mlast) begin b_beats++; b_data = b_mdata; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] crc24(input logic [87:0] msg);
    logic [23:0] c;
    logic        fb;
    c = '0;
    for (int i = 87; i >= 0; i--) begin
      fb = c[23] ^ msg[i];
      c  = {c[22:0], 1'b0} ^ (fb ? 24'hFFF409 : 24'h0);
    end
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 0; a_tvalid = 0; b_tvalid = 0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic send_main(input logic [111:0] f);
    s_tdata = f; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    s_tvalid = 0; a_tvalid = 0; b_tvalid = 0; s_tlast = 0; m_tready = 1; df_en = 1;
    s_tdata = '0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    n_tests++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b/%b want 0/0", m_tvalid, m_tlast); end
    n_tests++; if (m_tdata !== 112'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    n_tests++; if ({ok_cnt, fail_cnt, rej_cnt, drop_cnt} !== 128'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0 0 0 0", ok_cnt, fail_cnt, rej_cnt, drop_cnt); end
  endtask

  task automatic test_valid_df17();
    int b0, lat;
    do_reset(); df_en = 1; m_tready = 1; b0 = beats;
    send_main(F17);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (m_tvalid) begin lat = i; break; end
    end
    n_tests++; if (lat != 12) begin n_fail++; $display("FAIL df17_latency: got %0d want 12", lat); end
    cycles(3);
    n_tests++; if (beats - b0 != 1) begin n_fail++; $display("FAIL df17_beats: got %0d want 1", beats - b0); end
    n_tests++; if (beat_data !== F17 || beat_last !== 1'b1) begin n_fail++; $display("FAIL df17_data: got %h last %b want %h last 1", beat_data, beat_last, F17); end
    n_tests++; if (ok_cnt !== 32'd1) begin n_fail++; $display("FAIL df17_ok_count: got %0d want 1", ok_cnt); end
    n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL df17_tready_after: got %b want 1", s_tready); end
  endtask

  task automatic test_crc_fail();
    int b0;
    do_reset(); df_en = 1; m_tready = 1; b0 = beats;
    send_main(f17_bad);
    cycles(20);
    n_tests++; if (fail_cnt !== 32'd1) begin n_fail++; $display("FAIL crcfail_count: got %0d want 1", fail_cnt); end
    n_tests++; if ({ok_cnt, rej_cnt, drop_cnt} !== 96'd0) begin n_fail++; $display("FAIL crcfail_others: got %0d %0d %0d want 0 0 0", ok_cnt, rej_cnt, drop_cnt); end
    n_tests++; if (beats != b0) begin n_fail++; $display("FAIL crcfail_beats: got %0d want 0", beats - b0); end
  endtask

  task automatic test_df_filter();
    int b0;
    do_reset(); df_en = 1; m_tready = 1; b0 = beats;
    send_main(f20);
    cycles(20);
    n_tests++; if (rej_cnt !== 32'd1 || ok_cnt !== 32'd0 || fail_cnt !== 32'd0) begin n_fail++; $display("FAIL df20_filtered: got rej %0d ok %0d fail %0d want 1 0 0", rej_cnt, ok_cnt, fail_cnt); end
    n_tests++; if (beats != b0) begin n_fail++; $display("FAIL df20_filtered_beats: got %0d want 0", beats - b0); end
    df_en = 0;
    send_main(f20);
    cycles(20);
    n_tests++; if (ok_cnt !== 32'd1 || rej_cnt !== 32'd1) begin n_fail++; $display("FAIL df20_unfiltered: got ok %0d rej %0d want 1 1", ok_cnt, rej_cnt); end
    n_tests++; if (beats - b0 != 1 || beat_data !== f20) begin n_fail++; $display("FAIL df20_unfiltered_data: got %0d beats %h want 1 beat %h", beats - b0, beat_data, f20); end
  endtask

  task automatic test_df_sample();
    do_reset(); df_en = 1; m_tready = 1;
    send_main(f20);
    cycles(4);
    df_en = 0;
    cycles(20);
    n_tests++; if (ok_cnt !== 32'd1 || rej_cnt !== 32'd0) begin n_fail++; $display("FAIL df_sample_in_check: got ok %0d rej %0d want 1 0", ok_cnt, rej_cnt); end
    df_en = 1;
  endtask

  task automatic test_back_to_back();
    int b0;
    do_reset(); df_en = 1; m_tready = 1; b0 = beats;
    send_main(F17);
    cycles(2);
    s_tdata = f20; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    cycles(20);
    n_tests++; if (drop_cnt !== 32'd1) begin n_fail++; $display("FAIL b2b_dropped: got %0d want 1", drop_cnt); end
    n_tests++; if (ok_cnt !== 32'd1 || beats - b0 != 1) begin n_fail++; $display("FAIL b2b_delivered: got ok %0d beats %0d want 1 1", ok_cnt, beats - b0); end
    n_tests++; if (beat_data !== F17) begin n_fail++; $display("FAIL b2b_data: got %h want %h", beat_data, F17); end
  endtask

  task automatic test_stall();
    int b0, lat;
    do_reset(); df_en = 1; m_tready = 0; b0 = beats;
    send_main(F17);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (m_tvalid) begin lat = i; break; end
    end
    n_tests++; if (lat != 12) begin n_fail++; $display("FAIL stall_latency: got %0d want 12", lat); end
    for (int k = 0; k < 20; k++) begin
      s_tvalid = (k == 10);
      @(posedge clk); #1;
      n_tests++;
      if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== F17 || s_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v%b l%b r%b %h want v1 l1 r0 %h", k, m_tvalid, m_tlast, s_tready, m_tdata, F17);
      end
    end
    s_tvalid = 1'b0;
    n_tests++; if (drop_cnt !== 32'd1 || ok_cnt !== 32'd0 || beats != b0) begin n_fail++; $display("FAIL stall_counts: got drop %0d ok %0d beats %0d want 1 0 0", drop_cnt, ok_cnt, beats - b0); end
    m_tready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got v%b r%b want v0 r1", m_tvalid, s_tready); end
    n_tests++; if (ok_cnt !== 32'd1 || beats - b0 != 1) begin n_fail++; $display("FAIL stall_complete: got ok %0d beats %0d want 1 1", ok_cnt, beats - b0); end
  endtask

  task automatic test_reset_mid();
    int b0;
    do_reset(); df_en = 1; m_tready = 1;
    send_main(f17_bad);
    cycles(20);
    b0 = beats;
    send_main(F17);
    cycles(4);
    rst = 1'b1;
    #1;
    n_tests++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got r%b v%b want r1 v0", s_tready, m_tvalid); end
    cycles(2);
    rst = 1'b0;
    cycles(20);
    n_tests++; if (beats != b0) begin n_fail++; $display("FAIL midreset_beats: got %0d want 0", beats - b0); end
    n_tests++; if ({ok_cnt, fail_cnt, rej_cnt, drop_cnt} !== 128'd0) begin n_fail++; $display("FAIL midreset_counters: got %0d %0d %0d %0d want 0 0 0 0", ok_cnt, fail_cnt, rej_cnt, drop_cnt); end
    send_main(F17);
    cycles(20);
    n_tests++; if (ok_cnt !== 32'd1 || beats - b0 != 1 || beat_data !== F17) begin n_fail++; $display("FAIL midreset_recover: got ok %0d beats %0d %h want 1 1 %h", ok_cnt, beats - b0, beat_data, F17); end
  endtask

  task automatic test_bpc_sweep();
    logic [111:0] fr[4];
    logic         en[4];
    int           exp_la[4], exp_lb[4];
    int           la, lb, a0, b0;
    fr[0] = F17;     en[0] = 1; exp_la[0] = 89; exp_lb[0] = 2;
    fr[1] = f17_bad; en[1] = 1; exp_la[1] = -1; exp_lb[1] = -1;
    fr[2] = f20;     en[2] = 1; exp_la[2] = -1; exp_lb[2] = -1;
    fr[3] = f20;     en[3] = 0; exp_la[3] = 89; exp_lb[3] = 2;
    do_reset(); a0 = a_beats; b0 = b_beats;
    for (int c = 0; c < 4; c++) begin
      s_tdata = fr[c]; df_en = en[c]; a_tvalid = 1'b1; b_tvalid = 1'b1;
      @(posedge clk); #1;
      a_tvalid = 1'b0; b_tvalid = 1'b0;
      la = -1; lb = -1;
      for (int i = 1; i <= 120; i++) begin
        @(posedge clk); #1;
        if (a_mvalid && la < 0) la = i;
        if (b_mvalid && lb < 0) lb = i;
      end
      n_tests++; if (la != exp_la[c]) begin n_fail++; $display("FAIL sweep_b1_latency[%0d]: got %0d want %0d", c, la, exp_la[c]); end
      n_tests++; if (lb != exp_lb[c]) begin n_fail++; $display("FAIL sweep_b88_latency[%0d]: got %0d want %0d", c, lb, exp_lb[c]); end
    end
    n_tests++; if (a_ok !== 32'd2 || a_fail !== 32'd1 || a_rej !== 32'd1 || a_drop !== 32'd0) begin n_fail++; $display("FAIL sweep_b1_counts: got %0d %0d %0d %0d want 2 1 1 0", a_ok, a_fail, a_rej, a_drop); end
    n_tests++; if (b_ok !== 2'd2 || b_fail !== 2'd1 || b_rej !== 2'd1 || b_drop !== 2'd0) begin n_fail++; $display("FAIL sweep_b88_counts: got %0d %0d %0d %0d want 2 1 1 0", b_ok, b_fail, b_rej, b_drop); end
    n_tests++; if (a_beats - a0 != 2 || a_data !== f20) begin n_fail++; $display("FAIL sweep_b1_data: got %0d beats %h want 2 beats %h", a_beats - a0, a_data, f20); end
    n_tests++; if (b_beats - b0 != 2 || b_data !== f20) begin n_fail++; $display("FAIL sweep_b88_data: got %0d beats %h want 2 beats %h", b_beats - b0, b_data, f20); end
  endtask

  task automatic test_saturation();
    s_tdata = F17; df_en = 1; b_tvalid = 1'b1;
    cycles(30);
    b_tvalid = 1'b0;
    cycles(10);
    n_tests++; if (b_ok !== 2'd3 || b_drop !== 2'd3) begin n_fail++; $display("FAIL sat_counts: got ok %0d drop %0d want 3 3", b_ok, b_drop); end
    n_tests++; if (b_fail !== 2'd1 || b_rej !== 2'd1) begin n_fail++; $display("FAIL sat_others: got fail %0d rej %0d want 1 1", b_fail, b_rej); end
    n_tests++; if (b_tready !== 1'b1 || a_tready !== 1'b1 || a_drop !== 32'd0) begin n_fail++; $display("FAIL sat_idle: got br%b ar%b adrop %0d want 1 1 0", b_tready, a_tready, a_drop); end
  endtask

  initial begin
    f20     = {8'hA0, 80'h0000_1234_5678_9ABC_DEF0, 24'h0};
    f20     = {f20[111:24], crc24(f20[111:24])};
    f17_bad = F17 ^ (112'd1 << 60);
    test_reset();
    test_valid_df17();
    test_crc_fail();
    test_df_filter();
    test_df_sample();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_bpc_sweep();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
